// File: rtl/tcam_reg_cmd_rx.sv
// Register-bus frame receiver: collects TCAM command frames word by word and decodes key/mask/action.
// Optional macro TCAM_RX_TIMEOUT_EN adds an inter-word idle timeout in COLLECT.
module tcam_reg_cmd_rx #(
   parameter int LOOK_UP_DATA_WIDTH = 144,
   parameter int ACTION_WIDTH       = 24,
   parameter int REG_ADDR_BUS_WIDTH = 8,
   parameter int REG_DATA_BUS_WIDTH = 16,
   parameter int TIMEOUT_CYCLES     = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_reg_bus_we,
   input  logic [REG_ADDR_BUS_WIDTH-1:0] i_reg_bus_we_addr,
   input  logic [REG_DATA_BUS_WIDTH-1:0] i_reg_bus_we_din,
   input  logic                          i_reg_bus_we_din_v,
   output logic                          o_tcam_busy,
   output logic                          o_cmd_valid,
   input  logic                          i_cmd_ready,
   output logic [1:0]                    o_cmd_type,
   output logic [LOOK_UP_DATA_WIDTH-1:0] o_key_data,
   output logic [LOOK_UP_DATA_WIDTH-1:0] o_key_mask,
   output logic [ACTION_WIDTH-1:0]       o_action,
   input  logic                          i_err_clr,
   output logic [3:0]                    o_err_sticky
);
   localparam int FRAME_W   = 2 * (LOOK_UP_DATA_WIDTH + ACTION_WIDTH);
   localparam int NUM_WORDS = (FRAME_W + REG_DATA_BUS_WIDTH - 1) / REG_DATA_BUS_WIDTH;
   localparam int BUF_W     = NUM_WORDS * REG_DATA_BUS_WIDTH;
   localparam int CNT_W     = $clog2(NUM_WORDS + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DECODE = 2'd2, OUTPUT = 2'd3} state_t;

   state_t                          state_r, state_s;
   logic [CNT_W-1:0]                cnt_r, cnt_s;
   logic [1:0]                      type_r, type_s;
   logic [BUF_W-1:0]                frame_r;
   logic [FRAME_W-1:0]              frame_s;
   logic [LOOK_UP_DATA_WIDTH-1:0]   key_data_s, key_mask_s;
   logic [ACTION_WIDTH-1:0]         action_s;
   logic                            act_bad_s;
   logic [3:0]                      err_new_s;
   logic [1:0]                      addr_type_s;
   logic                            strobe_s, sub_ok_s, accept_s, timeout_s;

   assign addr_type_s = i_reg_bus_we_addr[7:6];
   assign strobe_s    = i_reg_bus_we && i_reg_bus_we_din_v;
   assign sub_ok_s    = (i_reg_bus_we_addr[5:0] == 6'd0);
   assign accept_s    = strobe_s && sub_ok_s && !o_tcam_busy && (addr_type_s != 2'b11);
   // Word 0 lands in the top of the shift buffer, so the frame sits MSB-aligned.
   assign frame_s     = frame_r[BUF_W-1 -: FRAME_W];

`ifdef TCAM_RX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] idle_cnt_r;

   // Idle-cycle counter between words of a frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_r <= '0;
      end else if ((state_r != COLLECT) || accept_s) begin
         idle_cnt_r <= '0;
      end else begin
         idle_cnt_r <= idle_cnt_r + TO_W'(1);
      end
   end

   assign timeout_s = (state_r == COLLECT) && !accept_s &&
                      (idle_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_s = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

   // Split the frame into key pairs (upper field) and action pairs (lower field).
   always_comb begin
      key_data_s = '0;
      key_mask_s = '0;
      action_s   = '0;
      act_bad_s  = 1'b0;
      for (int i = 0; i < LOOK_UP_DATA_WIDTH; i++) begin
         key_data_s[i] = frame_s[2*ACTION_WIDTH + 2*i];
         key_mask_s[i] = frame_s[2*ACTION_WIDTH + 2*i + 1];
      end
      for (int j = 0; j < ACTION_WIDTH; j++) begin
         action_s[j] = frame_s[2*j];
         act_bad_s   = act_bad_s | frame_s[2*j+1];
      end
   end

   // Next-state, word count, command type and new-error decode.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      type_s    = type_r;
      err_new_s = 4'b0000;
      err_new_s[0] = strobe_s && sub_ok_s && o_tcam_busy;
      err_new_s[3] = strobe_s && sub_ok_s && !o_tcam_busy && (addr_type_s == 2'b11);
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               type_s  = addr_type_s;
               cnt_s   = CNT_W'(1);
               state_s = (NUM_WORDS == 1) ? DECODE : COLLECT;
            end else begin
               cnt_s = '0;
            end
         end
         COLLECT: begin
            if (accept_s && (addr_type_s != type_r)) begin
               err_new_s[1] = 1'b1;
               type_s       = addr_type_s;
               cnt_s        = CNT_W'(1);
            end else if (accept_s && (cnt_r == CNT_W'(NUM_WORDS - 1))) begin
               cnt_s   = '0;
               state_s = DECODE;
            end else if (accept_s) begin
               cnt_s = cnt_r + CNT_W'(1);
            end else if (timeout_s) begin
               err_new_s[1] = 1'b1;
               cnt_s        = '0;
               state_s      = IDLE;
            end else begin
               cnt_s = cnt_r;
            end
         end
         DECODE: begin
            err_new_s[2] = act_bad_s;
            state_s      = OUTPUT;
         end
         OUTPUT: begin
            if (i_cmd_ready) begin
               state_s = IDLE;
            end else begin
               state_s = OUTPUT;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // State, frame buffer, decoded outputs and sticky error register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         cnt_r        <= '0;
         type_r       <= 2'b00;
         frame_r      <= '0;
         o_tcam_busy  <= 1'b0;
         o_cmd_valid  <= 1'b0;
         o_cmd_type   <= 2'b00;
         o_key_data   <= '0;
         o_key_mask   <= '0;
         o_action     <= '0;
         o_err_sticky <= 4'b0000;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         type_r      <= type_s;
         o_tcam_busy <= (state_s == DECODE) || (state_s == OUTPUT);
         o_cmd_valid <= (state_s == OUTPUT);
         if (accept_s) begin
            frame_r <= {frame_r[BUF_W-REG_DATA_BUS_WIDTH-1:0], i_reg_bus_we_din};
         end
         if (state_r == DECODE) begin
            o_cmd_type <= type_r;
            o_key_data <= key_data_s;
            o_key_mask <= key_mask_s;
            o_action   <= action_s;
         end
         o_err_sticky <= (i_err_clr ? 4'b0000 : o_err_sticky) | err_new_s;
      end
   end
endmodule

// File: tb/tb_tcam_reg_cmd_rx.sv
// Directed self-checking bench for tcam_reg_cmd_rx at default parameters.
// Define TCAM_RX_TIMEOUT_EN to also exercise the idle timeout.
module tb_tcam_reg_cmd_rx;
   logic         clk = 1'b0;
   logic         rst;
   logic         we, din_v, cmd_ready, err_clr;
   logic [7:0]   addr;
   logic [15:0]  din;
   logic         busy, cmd_valid;
   logic [1:0]   cmd_type;
   logic [143:0] key_data, key_mask;
   logic [23:0]  action;
   logic [3:0]   err;

   int tests = 0;
   int fails = 0;

   localparam logic [143:0] KEY_A  = 144'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF_0123;
   localparam logic [143:0] MASK_A = 144'hFF;
   localparam logic [23:0]  ACT_A  = 24'h654321;
   localparam logic [143:0] KEY_B  = 144'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210_FEDC;
   localparam logic [143:0] MASK_B = 144'hF0F0_0000_0000_0000_0000_0000_0000_0000_F0F0;
   localparam logic [23:0]  ACT_B  = 24'hA5A5A5;

   logic [335:0] fa, fb, fc;

   tcam_reg_cmd_rx dut (
      .clk(clk), .rst(rst),
      .i_reg_bus_we(we), .i_reg_bus_we_addr(addr), .i_reg_bus_we_din(din),
      .i_reg_bus_we_din_v(din_v),
      .o_tcam_busy(busy), .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready),
      .o_cmd_type(cmd_type), .o_key_data(key_data), .o_key_mask(key_mask),
      .o_action(action), .i_err_clr(err_clr), .o_err_sticky(err)
   );

   always #5 clk = ~clk;

   function automatic logic [335:0] mk_frame(input logic [143:0] k, input logic [143:0] m,
                                             input logic [23:0] a, input logic [23:0] bad);
      logic [335:0] f;
      f = '0;
      for (int i = 0; i < 144; i++) begin
         f[48 + 2*i]     = k[i];
         f[48 + 2*i + 1] = m[i];
      end
      for (int j = 0; j < 24; j++) begin
         f[2*j]     = a[j];
         f[2*j + 1] = bad[j];
      end
      return f;
   endfunction

   task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the capturing posedge.
   task automatic send_word(input logic [7:0] a, input logic [15:0] d);
      we = 1'b1; din_v = 1'b1; addr = a; din = d;
      @(negedge clk);
      we = 1'b0; din_v = 1'b0; addr = 8'h00; din = 16'h0000;
   endtask

   task automatic send_range(input logic [1:0] t, input logic [335:0] f, input int first, input int last);
      for (int w = first; w <= last; w++) send_word({t, 6'd0}, f[335 - 16*w -: 16]);
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_clr", {140'd0, err}, 144'd0);
   endtask

   task automatic chk_cmd(input string tag, input logic [1:0] t, input logic [143:0] k,
                          input logic [143:0] m, input logic [23:0] a);
      chk({tag, "_valid"}, {143'd0, cmd_valid}, 144'd1);
      chk({tag, "_type"}, {142'd0, cmd_type}, {142'd0, t});
      chk({tag, "_key"}, key_data, k);
      chk({tag, "_mask"}, key_mask, m);
      chk({tag, "_act"}, {120'd0, action}, {120'd0, a});
   endtask

   initial begin
      fa = mk_frame(KEY_A, MASK_A, ACT_A, 24'h000000);
      fb = mk_frame(KEY_B, MASK_B, ACT_B, 24'h000000);
      fc = mk_frame(KEY_B, MASK_A, ACT_A, 24'h000001);
      rst = 1'b1; we = 1'b0; din_v = 1'b0; addr = 8'h00; din = 16'h0000;
      cmd_ready = 1'b1; err_clr = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_busy", {143'd0, busy}, 144'd0);
      chk("rst_valid", {143'd0, cmd_valid}, 144'd0);
      chk("rst_err", {140'd0, err}, 144'd0);
      chk("rst_key", key_data, 144'd0);
      chk("rst_act", {120'd0, action}, 144'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic write frame with ready high: valid two cycles after last strobe, one cycle wide
      send_range(2'b00, fa, 0, 0);
      chk("col_busy", {143'd0, busy}, 144'd0);
      send_range(2'b00, fa, 1, 20);
      chk("dec_busy", {143'd0, busy}, 144'd1);
      chk("dec_valid", {143'd0, cmd_valid}, 144'd0);
      @(negedge clk);
      chk_cmd("wr", 2'b00, KEY_A, MASK_A, ACT_A);
      chk("wr_err", {140'd0, err}, 144'd0);
      @(negedge clk);
      chk("wr_drop", {143'd0, cmd_valid}, 144'd0);
      chk("wr_idle_busy", {143'd0, busy}, 144'd0);

      // Back-pressure: outputs held, word during busy dropped with err bit0
      cmd_ready = 1'b0;
      send_range(2'b00, fa, 0, 20);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            we = 1'b1; din_v = 1'b1; addr = 8'h00; din = 16'hFFFF;
         end
         @(negedge clk);
         we = 1'b0; din_v = 1'b0;
         chk("hold_valid", {143'd0, cmd_valid}, 144'd1);
         chk("hold_busy", {143'd0, busy}, 144'd1);
         chk("hold_key", key_data, KEY_A);
         chk("hold_act", {120'd0, action}, {120'd0, ACT_A});
      end
      chk("busy_err", {140'd0, err}, 144'd1);
      cmd_ready = 1'b1;
      @(negedge clk);
      chk("bp_release", {143'd0, cmd_valid}, 144'd0);
      clear_err();

      // Type change mid-frame aborts; the new word starts a new frame
      send_range(2'b00, fa, 0, 4);
      send_range(2'b01, fb, 0, 0);
      chk("abort_err", {140'd0, err}, 144'd2);
      send_range(2'b01, fb, 1, 20);
      @(negedge clk);
      chk_cmd("mod", 2'b01, KEY_B, MASK_B, ACT_B);
      repeat (3) begin
         @(negedge clk);
         chk("mod_single", {143'd0, cmd_valid}, 144'd0);
      end
      clear_err();

      // Illegal command and non-zero sub-address mid-frame do not disturb the frame
      send_range(2'b01, fa, 0, 6);
      send_word(8'hC0, 16'hFFFF);
      chk("ill_err", {140'd0, err}, 144'd8);
      send_word(8'h41, 16'hDEAD);
      chk("subaddr_err", {140'd0, err}, 144'd8);
      send_range(2'b01, fa, 7, 20);
      @(negedge clk);
      chk_cmd("ill", 2'b01, KEY_A, MASK_A, ACT_A);
      chk("ill_err_keep", {140'd0, err}, 144'd8);
      clear_err();

      // Clear and new error in the same cycle: new error wins
      err_clr = 1'b1;
      send_word(8'hC0, 16'h0000);
      err_clr = 1'b0;
      chk("clr_vs_new", {140'd0, err}, 144'd8);
      clear_err();

      // Bad action code: err bit2, data bit still used
      send_range(2'b10, fc, 0, 20);
      @(negedge clk);
      chk_cmd("del", 2'b10, KEY_B, MASK_A, ACT_A);
      chk("bad_act_err", {140'd0, err}, 144'd4);
      @(negedge clk);
      clear_err();

      // Reset mid-frame: nothing emitted until a full new frame
      send_range(2'b00, fb, 0, 9);
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", {143'd0, cmd_valid}, 144'd0);
      chk("rst_mid_key", key_data, 144'd0);
      chk("rst_mid_err", {140'd0, err}, 144'd0);
      @(negedge clk);
      rst = 1'b0;
      send_range(2'b00, fa, 0, 19);
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_cmd", {143'd0, cmd_valid}, 144'd0);
      end
      send_range(2'b00, fa, 20, 20);
      @(negedge clk);
      chk_cmd("post_rst", 2'b00, KEY_A, MASK_A, ACT_A);
      @(negedge clk);

      // Reset while a command is pending
      cmd_ready = 1'b0;
      send_range(2'b00, fb, 0, 20);
      @(negedge clk);
      chk("pend_valid", {143'd0, cmd_valid}, 144'd1);
      rst = 1'b1;
      #1;
      chk("pend_rst_valid", {143'd0, cmd_valid}, 144'd0);
      chk("pend_rst_busy", {143'd0, busy}, 144'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("pend_gone", {143'd0, cmd_valid}, 144'd0);
      end
      cmd_ready = 1'b1;

`ifdef TCAM_RX_TIMEOUT_EN
      // Idle timeout drops a partial frame
      send_range(2'b00, fb, 0, 2);
      repeat (250) @(negedge clk);
      chk("to_early", {140'd0, err}, 144'd0);
      repeat (50) @(negedge clk);
      chk("to_err", {140'd0, err}, 144'd2);
      send_range(2'b00, fa, 0, 20);
      @(negedge clk);
      chk_cmd("to", 2'b00, KEY_A, MASK_A, ACT_A);
      @(negedge clk);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/tcam_reg_cmd_rx.md
TCAM_REG_CMD_RX -- requirements
Module: tcam_reg_cmd_rx

Interface
REQ-001 SHALL have parameter LOOK_UP_DATA_WIDTH, default 144, key width in bits.
REQ-002 SHALL have parameter ACTION_WIDTH, default 24, action width in bits.
REQ-003 SHALL have parameter REG_ADDR_BUS_WIDTH, default 8, register address width.
REQ-004 SHALL have parameter REG_DATA_BUS_WIDTH, default 16, register data width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum idle cycles allowed between words of one frame.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port i_reg_bus_we  input  1  register write strobe.
REQ-009 SHALL have port i_reg_bus_we_addr  input  REG_ADDR_BUS_WIDTH  [7:6] command type, [5:0] sub-address.
REQ-010 SHALL have port i_reg_bus_we_din  input  REG_DATA_BUS_WIDTH  one frame word.
REQ-011 SHALL have port i_reg_bus_we_din_v  input  1  data-valid qualifier.
REQ-012 SHALL have port o_tcam_busy  output  1  frame held; new words refused.
REQ-013 SHALL have port o_cmd_valid  output  1  decoded command available.
REQ-014 SHALL have port i_cmd_ready  input  1  TCAM core accepts the command.
REQ-015 SHALL have port o_cmd_type  output  2  00 write, 01 modify, 10 delete.
REQ-016 SHALL have port o_key_data  output  LOOK_UP_DATA_WIDTH  decoded key bits.
REQ-017 SHALL have port o_key_mask  output  LOOK_UP_DATA_WIDTH  1 = don't care.
REQ-018 SHALL have port o_action  output  ACTION_WIDTH  decoded action.
REQ-019 SHALL have port i_err_clr  input  1  clears o_err_sticky for one cycle.
REQ-020 SHALL have port o_err_sticky  output  4  bit0 dropped word, bit1 aborted frame, bit2 bad action code, bit3 illegal command.

Function
REQ-021 A word is accepted when we, din_v and addr[5:0]==0 are all high, o_tcam_busy is low, and addr[7:6]!=11.
REQ-022 A frame is 2*(LOOK_UP_DATA_WIDTH+ACTION_WIDTH) bits, which is 336 bits in 21 words at the defaults. Word 0 carries frame bits [335:320], MSB first.
REQ-023 Frame layout is {key pairs, action pairs}. Pair i occupies bits [2i+1:2i]. Bit 2i+1 is the don't-care flag and bit 2i is the data bit.
REQ-024 The FSM SHALL have states IDLE, COLLECT, DECODE and OUTPUT.
REQ-025 IDLE to COLLECT on the first accepted word. That word's addr[7:6] is latched as the command type and the word count becomes 1.
REQ-026 COLLECT to DECODE on the cycle the final word is accepted. Word counts of 0..20 are legal.
REQ-027 DECODE lasts one cycle and registers o_key_data, o_key_mask and o_action. It sets err bit2 if any action pair has bit1 set; the data bit is still used.
REQ-028 o_cmd_valid SHALL rise exactly 2 cycles after the final word's strobe cycle.
REQ-029 o_tcam_busy SHALL be high in DECODE and OUTPUT and low in IDLE and COLLECT.
REQ-030 In OUTPUT, o_cmd_valid and all data outputs are held stable until i_cmd_ready is high. The FSM then returns to IDLE on the next edge and o_cmd_valid drops.
REQ-031 A strobe with we and din_v high while o_tcam_busy is high SHALL be discarded and set err bit0.
REQ-032 A strobe with addr[7:6]==11 SHALL be discarded and set err bit3. A partial frame in progress is unaffected.
REQ-033 A word in COLLECT whose addr[7:6] differs from the latched type SHALL abort the partial frame and set err bit1. That word becomes word 0 of a new frame.
REQ-034 Strobes with addr[5:0]!=0 SHALL be ignored with no error.
REQ-035 Error bits are sticky (OR-accumulated). When i_err_clr is asserted in the same cycle as a new error, the new error wins.

Reset
REQ-036 While rst is high, the FSM SHALL be IDLE, the word count 0, and all outputs 0, including o_tcam_busy, o_cmd_valid and o_err_sticky.
REQ-037 rst asserted mid-frame or in OUTPUT SHALL discard all partial or pending data, with no command emitted after release.

Configuration
REQ-038 When macro TCAM_RX_TIMEOUT_EN is defined, a counter runs in COLLECT. It is cleared on each accepted word.
REQ-039 When that counter reaches TIMEOUT_CYCLES, the partial frame is dropped, err bit1 is set and the FSM returns to IDLE.
REQ-040 When TCAM_RX_TIMEOUT_EN is undefined, no counter is built and COLLECT waits indefinitely.

Verification
REQ-041 Scenario: 21 words encoding key 144'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF_0123, mask 144'hFF, action 24'h654321, cmd 00, i_cmd_ready high. Required: o_cmd_valid rises 2 cycles after word 21 for exactly 1 cycle; data, mask and action match; o_cmd_type=00; err=0.
REQ-042 Scenario: same frame with i_cmd_ready low for 10 cycles. Required: outputs stable and o_tcam_busy high throughout. A word sent in that window sets err bit0 and does not change the outputs.
REQ-043 Scenario: 5 words of cmd 00, then one word of cmd 01, then 20 more words of cmd 01. Required: err bit1 set; a single command with o_cmd_type=01 is emitted.
REQ-044 Scenario: a strobe with addr=8'hC0 mid-frame. Required: err bit3 set; the frame completes normally. Then i_err_clr=1 makes o_err_sticky read 0.
REQ-045 Scenario (TCAM_RX_TIMEOUT_EN defined): 3 words, then 300 idle cycles, then 21 words. Required: err bit1 set after 255 idle cycles; one correct command emitted.
REQ-046 Scenario: rst pulsed after word 10. Required: all outputs 0; no o_cmd_valid until a full new frame of 21 words is received.
